seg_display_ctrl: RTL and testbench

Sequencer that turns a signed 16-bit binary value into four 4-bit digit codes for the board's four 7-segment decoders (HEX3..HEX0). Conversion uses a multi-cycle shift-and-add-3 (double-dabble) engine with a start/busy/done handshake. It also applies leading-zero blanking, places a minus sign and shows "----" for out-of-range values. Sits between application logic (counters, sensor readouts) and the per-digit decoders; the decoders stay purely combinational.

---
 rtl/seg_display_ctrl_pkg.sv | 17 +
 rtl/seg_display_ctrl_bcd_add3.sv | 10 +
 rtl/seg_display_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_display_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants and types for the 7-segment display sequencer.
// Decoder codes, FSM state encoding and the double-dabble shift count.
package seg_display_pkg;

   localparam logic [3:0] CODE_BLANK = 4'hA;
   localparam logic [3:0] CODE_DASH  = 4'hF;

   localparam int SHIFT_CNT = 14;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      SHIFT  = 2'd2,
      FORMAT = 2'd3
   } state_e;

endpackage

// File: rtl/seg_display_ctrl_bcd_add3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more
// so that the following left shift carries correctly into the next decade.
module bcd_add3 (
   input  logic [3:0] din_i,
   output logic [3:0] dout_o
);

   assign dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;

endmodule

// File: rtl/seg_display_ctrl.sv
// Signed 16-bit value to four decoder digit codes via a multi-cycle
// double-dabble engine, with leading-zero blanking, minus sign and overflow dashes.
module seg_display_ctrl
   import seg_display_pkg::*;
#(
   parameter int BLANK_LZ = 1,
   parameter int MAX_POS  = 9999,
   parameter int MIN_NEG  = -999
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iSTART,
   input  logic [15:0] iVALUE,
   output logic        oBUSY,
   output logic        oDONE,
   output logic [3:0]  oDIGIT3,
   output logic [3:0]  oDIGIT2,
   output logic [3:0]  oDIGIT1,
   output logic [3:0]  oDIGIT0
);

   localparam logic signed [15:0] MAX_POS_V = 16'(MAX_POS);
   localparam logic signed [15:0] MIN_NEG_V = 16'(MIN_NEG);

   state_e              state_q, state_d;
   logic signed [15:0]  value_q, value_d;
   logic                neg_q, neg_d;
   logic                oor_q, oor_d;
   logic [15:0]         bcd_q, bcd_d;
   logic [13:0]         mag_q, mag_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [15:0]         digit_q, digit_d;

   logic [15:0]         bcd_adj;
   logic [29:0]         shifted;
   logic                out_of_range;
   logic [13:0]         magnitude;
   logic [15:0]         fmt_digits;
   logic                blank3, blank2, blank1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .din_i  (bcd_q[gi*4 +: 4]),
            .dout_o (bcd_adj[gi*4 +: 4])
         );
      end
   endgenerate

   assign shifted      = {bcd_adj, mag_q} << 1;
   assign out_of_range = (value_q > MAX_POS_V) || (value_q < MIN_NEG_V);
   // Low 14 bits of the negation only depend on the low 14 input bits; in-range values fit.
   assign magnitude    = value_q[15] ? (~value_q[13:0] + 14'd1) : value_q[13:0];

   always_comb begin
      blank3     = (bcd_q[15:12] == 4'd0);
      blank2     = blank3 && (bcd_q[11:8] == 4'd0);
      blank1     = blank2 && (bcd_q[7:4] == 4'd0);
      fmt_digits = bcd_q;
      if (oor_q) begin
         fmt_digits = {4{CODE_DASH}};
      end else if (BLANK_LZ == 0) begin
         if (neg_q) fmt_digits[15:12] = CODE_DASH;
      end else begin
         if (blank3) fmt_digits[15:12] = CODE_BLANK;
         if (blank2) fmt_digits[11:8]  = CODE_BLANK;
         if (blank1) fmt_digits[7:4]   = CODE_BLANK;
         // Dash takes the lowest blanked slot, just left of the leading numeral.
         if (neg_q) begin
            if (blank1)      fmt_digits[7:4]   = CODE_DASH;
            else if (blank2) fmt_digits[11:8]  = CODE_DASH;
            else             fmt_digits[15:12] = CODE_DASH;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      neg_d   = neg_q;
      oor_d   = oor_q;
      bcd_d   = bcd_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      digit_d = digit_q;
      case (state_q)
         IDLE: begin
            if (iSTART) begin
               value_d = iVALUE;
               busy_d  = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            neg_d   = value_q[15];
            oor_d   = out_of_range;
            mag_d   = magnitude;
            bcd_d   = 16'd0;
            cnt_d   = 4'd0;
            state_d = out_of_range ? FORMAT : SHIFT;
         end
         SHIFT: begin
            {bcd_d, mag_d} = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(SHIFT_CNT - 1)) state_d = FORMAT;
         end
         FORMAT: begin
            digit_d = fmt_digits;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= IDLE;
         value_q <= '0;
         neg_q   <= 1'b0;
         oor_q   <= 1'b0;
         bcd_q   <= '0;
         mag_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         digit_q <= {4{CODE_BLANK}};
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         neg_q   <= neg_d;
         oor_q   <= oor_d;
         bcd_q   <= bcd_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         digit_q <= digit_d;
      end
   end

   assign oBUSY   = busy_q;
   assign oDONE   = done_q;
   assign oDIGIT3 = digit_q[15:12];
   assign oDIGIT2 = digit_q[11:8];
   assign oDIGIT1 = digit_q[7:4];
   assign oDIGIT0 = digit_q[3:0];

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: one instance with leading-zero
// blanking, one without, both driven by the same stimulus.
module tb_seg_display_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] value;
   logic        busy, done, busy_nz, done_nz;
   logic [3:0]  d3, d2, d1, d0, n3, n2, n1, n0;
   logic [15:0] dig_lz, dig_nz;

   int checks = 0;
   int errors = 0;

   assign dig_lz = {d3, d2, d1, d0};
   assign dig_nz = {n3, n2, n1, n0};

   seg_display_ctrl #(.BLANK_LZ(1)) dut (
      .iCLK(clk), .iRST(rst), .iSTART(start), .iVALUE(value),
      .oBUSY(busy), .oDONE(done),
      .oDIGIT3(d3), .oDIGIT2(d2), .oDIGIT1(d1), .oDIGIT0(d0)
   );

   seg_display_ctrl #(.BLANK_LZ(0)) dut_nz (
      .iCLK(clk), .iRST(rst), .iSTART(start), .iVALUE(value),
      .oBUSY(busy_nz), .oDONE(done_nz),
      .oDIGIT3(n3), .oDIGIT2(n2), .oDIGIT1(n1), .oDIGIT0(n0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns at the negedge just after the accepting edge E0.
   task automatic pulse_start(input logic [15:0] v);
      @(negedge clk);
      start = 1'b1;
      value = v;
      @(negedge clk);
      start = 1'b0;
      value = 16'h0BAD;
   endtask

   task automatic convert(input logic [15:0] v, input logic [15:0] exp_lz,
                          input logic [15:0] exp_nz, input int exp_lat);
      int n;
      bit busy_ok;
      pulse_start(v);
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check("latency", 16'(n), 16'(exp_lat));
      check("busy_during", 16'(busy_ok), 16'd1);
      check("done_nz", 16'(done_nz), 16'd1);
      check("digits_lz", dig_lz, exp_lz);
      check("digits_nz", dig_nz, exp_nz);
      check("busy_after", 16'(busy), 16'd0);
      $display("convert value=%0d latency=%0d lz=%h nz=%h", $signed(v), n, dig_lz, dig_nz);
      @(negedge clk);
      check("done_pulse", 16'(done), 16'd0);
   endtask

   initial begin
      int ndone;
      rst = 1'b1;
      start = 1'b0;
      value = 16'd0;

      @(negedge clk);
      check("rst_digits", dig_lz, 16'hAAAA);
      check("rst_busy", 16'(busy), 16'd0);
      repeat (3) @(negedge clk);
      check("rst_hold_digits", dig_lz, 16'hAAAA);
      check("rst_hold_done", 16'(done), 16'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_digits", dig_nz, 16'hAAAA);
      check("idle_busy", 16'(busy), 16'd0);
      $display("reset sequence done");

      convert(16'd1234,           16'h1234, 16'h1234, 16);
      convert(16'd7,              16'hAAA7, 16'h0007, 16);
      convert(16'd0,              16'hAAA0, 16'h0000, 16);
      convert(16'(-42),           16'hAF42, 16'hF042, 16);
      convert(16'(-999),          16'hF999, 16'hF999, 16);
      convert(16'd9999,           16'h9999, 16'h9999, 16);
      convert(16'd10000,          16'hFFFF, 16'hFFFF, 2);
      convert(16'(-1000),         16'hFFFF, 16'hFFFF, 2);
      convert(16'h8000,           16'hFFFF, 16'hFFFF, 2);

      // Second start while busy must be ignored; prior FFFF holds until E0+16.
      pulse_start(16'd5555);
      ndone = 0;
      for (int n = 0; n < 24; n++) begin
         if (n == 4) begin
            start = 1'b1;
            value = 16'd1111;
         end
         if (n == 5) start = 1'b0;
         if (done) ndone++;
         if (n == 15) check("busy_hold_digits", dig_lz, 16'hFFFF);
         if (n == 16) begin
            check("busy_result", dig_lz, 16'h5555);
            check("busy_done", 16'(done), 16'd1);
         end
         @(negedge clk);
      end
      check("busy_done_count", 16'(ndone), 16'd1);
      check("busy_final", dig_nz, 16'h5555);
      $display("busy test done_count=%0d digits=%h", ndone, dig_lz);

      // Reset at E0+8 aborts the conversion.
      pulse_start(16'd1234);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_digits", dig_lz, 16'hAAAA);
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_done", 16'(done), 16'd0);
      rst = 1'b0;
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", 16'(ndone), 16'd0);
      $display("abort test digits=%h", dig_lz);

      convert(16'(-5),            16'hAAF5, 16'hF005, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
